// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC sine/cosine datapath and its phase front end.
// Angles are Q2.6 radians; phase is an unsigned fraction of a full turn.
package cordic_pkg;

  localparam int PHASE_W     = 16;
  localparam int ITER_CYCLES = 11;
  localparam int ANGLE_W     = 8;
  localparam int ANGLE_FRAC  = 6;

  // 2*pi*2^ANGLE_FRAC scaled by 2^16 / 2^PHASE_W; only exact for PHASE_W = 16.
  localparam int K_RAD  = 402;
  localparam int PROD_W = 25;

  localparam logic [11:0] CORDIC_GAIN_INIT = 12'b00_1001101110;

endpackage

// File: rtl/angle_fold.sv
// Folds a full-turn phase into [-pi/2, pi/2] and scales it to a Q2.6 radian angle.
// neg_o flags that sine and cosine of the folded angle must both be negated.
module angle_fold #(
  parameter int PHASE_W = cordic_pkg::PHASE_W
) (
  input  logic [PHASE_W-1:0]                   phase_i,
  output logic signed [cordic_pkg::ANGLE_W-1:0] angle_o,
  output logic                                  neg_o
);
  import cordic_pkg::*;

  logic                       quadNeg;
  logic signed [PHASE_W-1:0]  folded;
  logic signed [PROD_W-1:0]   prod;
  logic signed [PROD_W-1:0]   rounded;
  logic                       unusedRoundBits;

  // Quadrants 1 and 2 are rotated by pi (MSB flip) so the core only sees |angle| <= pi/2.
  assign quadNeg = phase_i[PHASE_W-1] ^ phase_i[PHASE_W-2];
  assign folded  = quadNeg ? $signed({~phase_i[PHASE_W-1], phase_i[PHASE_W-2:0]})
                           : $signed(phase_i);

  assign prod    = PROD_W'(folded) * PROD_W'(K_RAD);
  assign rounded = prod + PROD_W'(1 << (PHASE_W - 1));

  assign angle_o = rounded[PHASE_W+ANGLE_W-1:PHASE_W];
  assign neg_o   = quadNeg;

  assign unusedRoundBits = ^{rounded[PROD_W-1:PHASE_W+ANGLE_W], rounded[PHASE_W-1:0]};

endmodule

// File: rtl/cordic_phase_gen.sv
// Phase accumulator feeding the iterative CORDIC core: advances once per slot,
// presents the folded Q2.6 angle and tracks the negate flag for the result in flight.
module cordic_phase_gen #(
  parameter int PHASE_W     = cordic_pkg::PHASE_W,
  parameter int ITER_CYCLES = cordic_pkg::ITER_CYCLES
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  en_i,
  input  logic [PHASE_W-1:0]                    freq_word_i,
  input  logic                                  freq_load_i,
  input  logic                                  phase_clr_i,
  output logic signed [cordic_pkg::ANGLE_W-1:0] angle_out_o,
  output logic                                  strobe_o,
  output logic                                  cur_neg_o,
  output logic                                  res_neg_o
);
  import cordic_pkg::*;

  localparam int                CNT_W    = $clog2(ITER_CYCLES);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(ITER_CYCLES - 1);

  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [PHASE_W-1:0]        phase_q, phase_d;
  logic [PHASE_W-1:0]        freq_q, freq_d;
  logic                      pend_q, pend_d;
  logic signed [ANGLE_W-1:0] angle_q, angle_d;
  logic                      cur_neg_q, cur_neg_d;
  logic                      res_neg_q, res_neg_d;

  logic                      boundary;
  logic [PHASE_W-1:0]        phaseNext;
  logic signed [ANGLE_W-1:0] foldAngle;
  logic                      foldNeg;

  assign boundary = (cnt_q == LAST_CNT);

  // A clear arriving on the boundary edge itself still wins over the increment.
  always_comb begin
    phaseNext = phase_q;
    if (pend_q || phase_clr_i) begin
      phaseNext = '0;
    end else if (en_i) begin
      phaseNext = phase_q + freq_q;
    end
  end

  angle_fold #(
    .PHASE_W (PHASE_W)
  ) u_fold (
    .phase_i (phaseNext),
    .angle_o (foldAngle),
    .neg_o   (foldNeg)
  );

  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    phase_d   = phase_q;
    freq_d    = freq_q;
    pend_d    = pend_q | phase_clr_i;
    angle_d   = angle_q;
    cur_neg_d = cur_neg_q;
    res_neg_d = res_neg_q;

    if (freq_load_i) begin
      freq_d = freq_word_i;
    end

    // res_neg takes the old cur_neg: the core result lags its angle by one slot.
    if (boundary) begin
      cnt_d     = '0;
      phase_d   = phaseNext;
      angle_d   = foldAngle;
      cur_neg_d = foldNeg;
      res_neg_d = cur_neg_q;
      pend_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      phase_q   <= '0;
      freq_q    <= '0;
      pend_q    <= 1'b0;
      angle_q   <= '0;
      cur_neg_q <= 1'b0;
      res_neg_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      freq_q    <= freq_d;
      pend_q    <= pend_d;
      angle_q   <= angle_d;
      cur_neg_q <= cur_neg_d;
      res_neg_q <= res_neg_d;
    end
  end

  assign angle_out_o = angle_q;
  assign strobe_o    = boundary;
  assign cur_neg_o   = cur_neg_q;
  assign res_neg_o   = res_neg_q;

endmodule

// File: doc/cordic_phase_gen.md
# cordic_phase_gen

Phase-accumulator front end that feeds the iterative CORDIC sine/cosine core. It advances a PHASE_W-bit phase by a programmable frequency word once per CORDIC slot, which is ITER_CYCLES clocks. It folds the phase into [-π/2, π/2] and scales it to the core's 8-bit Q2.6 radian angle format. It also emits a per-result negate flag so that a downstream stage can restore full-circle sine/cosine signs.

## Interface
- PHASE_W, 16, phase accumulator width; 2^PHASE_W represents one full turn (2π).
- ITER_CYCLES, 11, clocks per CORDIC slot (10 iterations plus 1 load cycle).
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-low.
- en  in  1  1 = phase advances at each slot boundary; 0 = phase and angle are held, slots keep running.
- freq_word  in  PHASE_W  unsigned phase increment per slot.
- freq_load  in  1  1-cycle pulse; captures freq_word into the frequency register.
- phase_clr  in  1  1-cycle pulse; requests a phase reset to 0 at the next slot boundary.
- angle_out  out  8  signed Q2.6 radians, range [-100, +100] LSB; drives the CORDIC angle input.
- strobe  out  1  high in the last cycle of each slot, which is the cycle in which the core captures angle_out.
- cur_neg  out  1  negate flag for the angle currently on angle_out.
- res_neg  out  1  negate flag for the CORDIC result currently being output.

## Operation
- Slot counter cnt runs 0..ITER_CYCLES-1 and wraps. strobe = (cnt == ITER_CYCLES-1).
- Frequency register freq: on freq_load, freq <= freq_word. This happens immediately and is independent of cnt.
- Slot boundary is the rising edge on which strobe = 1.
  - pn = phase_clr_pending ? 0 : (en ? phase + freq : phase). The sum is computed modulo 2^PHASE_W.
  - phase <= pn, and {angle_out, cur_neg} <= fold(pn).
  - res_neg <= cur_neg, the old value. This aligns res_neg with the core's result for the angle captured one slot earlier.
  - phase_clr_pending is cleared at the boundary.
  - freq uses its value from before the edge. A freq_load on a boundary edge takes effect from the next boundary.
- phase_clr sets phase_clr_pending. If phase_clr and a boundary occur on the same edge, the clear is applied at that boundary.
- fold(p):
  - Interpret p as signed s.
  - If p[PHASE_W-1] != p[PHASE_W-2] (quadrant 1 or 2): s <= s with its MSB inverted (subtract π), and neg = 1.
  - Otherwise neg = 0.
  - angle = (s * K_RAD + 2^(PHASE_W-1)) >>> PHASE_W, arithmetic shift (floor after adding a half).
  - K_RAD = 402 = round(2π·64·2^PHASE_W / 2^PHASE_W · 2^16 / 2^PHASE_W), which is valid for PHASE_W = 16. The product is 25-bit signed.
  - The result always fits [-100, +100], so no saturation is needed.

## Timing
- Reset values: cnt = 0, phase = 0, freq = 0, phase_clr_pending = 0, angle_out = 0, cur_neg = 0, res_neg = 0, strobe = 0.
- Slot k spans cycles cnt = 0..10. angle_out and cur_neg are stable for the whole slot and change only on boundary edges.
- The first boundary after reset deassertion occurs 11 edges after release.
- Slot 0 after reset presents angle 0. Slot 1 presents fold(freq).
- The CORDIC result for slot k's angle appears at the core output from cycle 1 of slot k+2. res_neg equals slot k's cur_neg over that same interval.
- Reset asserted mid-slot clears all state asynchronously. Slot counting restarts at cnt = 0 after release, and no partial slot output is emitted.

## Structure
- Shared cordic_pkg holds:
  - PHASE_W and ITER_CYCLES defaults, and K_RAD = 402.
  - ANGLE_W = 8 and ANGLE_FRAC = 6 (Q2.6).
  - CORDIC_GAIN_INIT = 12'b00_1001101110.
- Sub-module angle_fold: combinational fold, multiply and round from the phase to {angle, neg}. It is reused by the bench model.
- The top level holds the counter, freq, phase, pending clear and output registers.

## Test plan
- Reset release, freq_load 0x1000, en = 1:
  - angle_out over successive slots = 0, 25, 50, 75, -100 (neg 1), -75 (neg 1).
  - strobe is exactly 1 cycle high every 11 cycles.
- Boundary phases using freq = 0x4000: angle sequence 0, -100 (neg 1), 0 (neg 1 at π), -100 (neg 0 at -π/2), 0 (neg 0, wrapped).
- freq_load pulsed on a boundary edge: that boundary uses the old freq, and the next boundary uses the new freq.
- en = 0 for 3 slots: angle_out and cur_neg are unchanged, strobe continues, and res_neg follows cur_neg one slot late.
- phase_clr mid-slot with phase = 0x3000: next boundary gives angle 0, cur_neg 0. The following boundary gives fold(freq).
- rst pulled low at cnt = 5: all outputs are 0 immediately. After release, the first strobe is 11 cycles later.
